// File: rtl/core2wb_pipe.sv
// Ibex req/gnt/rvalid to Wishbone B4 pipelined master with bounded outstanding requests and bus timeout.
// Optional CORE2WB_PIPE_STATS_EN adds saturating transaction/error counters.
module core2wb_pipe #(
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            core_req,
    output logic            core_gnt,
    input  logic            core_we,
    input  logic [DW/8-1:0] core_be,
    input  logic [AW-1:0]   core_addr,
    input  logic [DW-1:0]   core_wdata,
    output logic            core_rvalid,
    output logic [DW-1:0]   core_rdata,
    output logic            core_err,
    output logic            wb_cyc,
    output logic            wb_stb,
    output logic            wb_we,
    output logic [DW/8-1:0] wb_sel,
    output logic [AW-1:0]   wb_adr,
    output logic [DW-1:0]   wb_dat_o,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic            wb_ack,
    input  logic            wb_err,
    input  logic            wb_stall
`ifdef CORE2WB_PIPE_STATS_EN
    ,
    output logic [31:0]     stat_txn,
    output logic [15:0]     stat_err
`endif
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] MAX_O = CW'(MAX_OUTSTANDING);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {RUN, ABORT} state_t;

    state_t        state;
    logic [CW-1:0] outstanding;
    logic [TW-1:0] timer;
    logic          run;
    logic          rsp_ok;

    assign run      = (state == RUN);
    assign wb_stb   = core_req & run & (outstanding < MAX_O);
    assign core_gnt = wb_stb & ~wb_stall;
    assign wb_cyc   = run & (wb_stb | (outstanding != '0));
    assign wb_we    = core_we;
    assign wb_sel   = core_be;
    assign wb_adr   = core_addr;
    assign wb_dat_o = core_wdata;

    // Acks with nothing outstanding or after cyc was dropped are stray.
    assign rsp_ok = run & (wb_ack | wb_err) & (outstanding != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            outstanding <= '0;
            timer       <= '0;
            core_rvalid <= 1'b0;
            core_err    <= 1'b0;
            core_rdata  <= '0;
        end else begin
            case (state)
                RUN: begin
                    core_rvalid <= rsp_ok;
                    core_err    <= rsp_ok & wb_err;
                    if (rsp_ok)
                        core_rdata <= wb_dat_i;
                    outstanding <= outstanding + CW'(core_gnt) - CW'(rsp_ok);
                    if (outstanding == '0 || rsp_ok) begin
                        timer <= '0;
                    end else if (timer == T_LAST) begin
                        timer <= '0;
                        state <= ABORT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ABORT: begin
                    // One error response per lost request, oldest first.
                    core_rvalid <= 1'b1;
                    core_err    <= 1'b1;
                    core_rdata  <= '0;
                    outstanding <= outstanding - CW'(1);
                    timer       <= '0;
                    if (outstanding == CW'(1))
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef CORE2WB_PIPE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_txn <= '0;
            stat_err <= '0;
        end else begin
            if (core_gnt && stat_txn != '1)
                stat_txn <= stat_txn + 32'd1;
            if (core_rvalid && core_err && stat_err != '1)
                stat_err <= stat_err + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_core2wb_pipe.sv
// Directed and random checks of core2wb_pipe against a queue-based reference.
// Stats counters are checked when CORE2WB_PIPE_STATS_EN is defined.
module tb_core2wb_pipe;

    localparam int MO = 4;
    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        core_req;
    logic        core_gnt;
    logic        core_we;
    logic [3:0]  core_be;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_rvalid;
    logic [31:0] core_rdata;
    logic        core_err;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack;
    logic        wb_err;
    logic        wb_stall;
`ifdef CORE2WB_PIPE_STATS_EN
    logic [31:0] stat_txn;
    logic [15:0] stat_err;
`endif

    core2wb_pipe #(
        .AW(32), .DW(32), .MAX_OUTSTANDING(MO), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_gnt(core_gnt), .core_we(core_we),
        .core_be(core_be), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rvalid(core_rvalid), .core_rdata(core_rdata), .core_err(core_err),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
        .wb_adr(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack(wb_ack), .wb_err(wb_err), .wb_stall(wb_stall)
`ifdef CORE2WB_PIPE_STATS_EN
        , .stat_txn(stat_txn), .stat_err(stat_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {logic [31:0] addr; bit err;} req_t;
    typedef struct {logic [31:0] addr; bit err; int due;} sl_t;

    req_t mq[$];
    sl_t  sq[$];
    int   m_out, m_idle, cyc_n, n_chk, n_fail, dut_gnts;
    bit   m_abort, mute, spur, both, req_err, last_gnt;
    int   lat;
    longint s_txn, s_err;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        m_out = 0; m_idle = 0; m_abort = 0;
        mq.delete(); sq.delete();
        s_txn = 0; s_err = 0;
    endtask

    task automatic cycle();
        bit stb_e, gnt_e, cyc_e, v, qual, e_v, e_err;
        logic [31:0] e_data;
        wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = $urandom;
        if (!mute && sq.size() > 0 && sq[0].due <= cyc_n) begin
            wb_dat_i = ~sq[0].addr;
            wb_err   = sq[0].err;
            wb_ack   = !sq[0].err || both;
            void'(sq.pop_front());
        end else if (spur) begin
            wb_ack = 1'b1;
        end
        @(negedge clk);
        stb_e = core_req && !m_abort && m_out < MO;
        gnt_e = stb_e && !wb_stall;
        cyc_e = !m_abort && (stb_e || m_out > 0);
        chk("wb_stb", wb_stb, stb_e);
        chk("core_gnt", core_gnt, gnt_e);
        chk("wb_cyc", wb_cyc, cyc_e);
        chk("wb_adr", wb_adr, core_addr);
        chk("wb_sel", wb_sel, core_be);
        chk("wb_we", wb_we, core_we);
        chk("wb_dat_o", wb_dat_o, core_wdata);
        if (core_gnt === 1'b1) dut_gnts++;
        e_v = 0; e_err = 0; e_data = '0;
        if (m_abort) begin
            e_v = 1; e_err = 1; e_data = '0;
            void'(mq.pop_front());
            m_out--;
            if (m_out == 0) m_abort = 0;
        end else begin
            v = m_out > 0 && (wb_ack || wb_err);
            if (v) begin
                e_v = 1; e_err = mq[0].err; e_data = ~mq[0].addr;
                void'(mq.pop_front());
            end
            if (gnt_e) begin
                mq.push_back('{core_addr, req_err});
                sq.push_back('{core_addr, req_err, cyc_n + lat});
                s_txn++;
            end
            qual = m_out > 0 && !v;
            m_out = m_out + int'(gnt_e) - int'(v);
            m_idle = qual ? m_idle + 1 : 0;
            if (m_idle == TO) begin
                m_abort = 1; m_idle = 0; sq.delete();
            end
        end
        @(posedge clk);
        #1;
        chk("core_rvalid", core_rvalid, e_v);
        if (e_v) begin
            chk("core_err", core_err, e_err);
            chk("core_rdata", core_rdata, e_data);
        end
`ifdef CORE2WB_PIPE_STATS_EN
        chk("stat_txn", stat_txn, s_txn[31:0]);
        chk("stat_err", stat_err, s_err[15:0]);
`endif
        if (e_v && e_err) s_err++;
        last_gnt = gnt_e;
        cyc_n++;
    endtask

    task automatic do_reset();
        rst = 1'b1; core_req = 1'b0; wb_stall = 1'b0;
        wb_ack = 1'b0; wb_err = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        chk("rst_rvalid", core_rvalid, 1'b0);
        chk("rst_err", core_err, 1'b0);
        chk("rst_rdata", core_rdata, 32'h0);
        chk("rst_cyc", wb_cyc, 1'b0);
        chk("rst_stb", wb_stb, 1'b0);
        chk("rst_gnt", core_gnt, 1'b0);
`ifdef CORE2WB_PIPE_STATS_EN
        chk("rst_stat_txn", stat_txn, 32'h0);
        chk("rst_stat_err", stat_err, 16'h0);
`endif
    endtask

    initial begin
        int n, k;
        n_chk = 0; n_fail = 0; cyc_n = 0; dut_gnts = 0;
        mute = 0; spur = 0; both = 0; req_err = 0; lat = 1;
        core_we = 0; core_be = 4'hF; core_addr = '0; core_wdata = '0;
        wb_dat_i = '0;
        model_clear();
        do_reset();

        // single read, data comes back as DEADBEEF
        core_req = 1; core_addr = 32'h2152_4110;
        cycle();
        core_req = 0;
        repeat (4) cycle();

        // burst of 6 reads, slave latency 5
        lat = 5; n = 0; k = 0; dut_gnts = 0;
        core_req = 1; core_addr = 32'h0000_1000;
        while (n < 6 && k < 60) begin
            cycle();
            if (last_gnt) begin
                n++;
                core_addr += 4;
            end
            k++;
        end
        core_req = 0;
        chk("burst_grants", dut_gnts, 6);
        repeat (12) cycle();

        // stall holds strobe for three cycles
        lat = 2; core_req = 1; core_addr = 32'h0000_2000;
        wb_stall = 1;
        repeat (3) cycle();
        wb_stall = 0;
        cycle();
        core_req = 0;
        repeat (4) cycle();

        // write answered with err
        core_we = 1; core_wdata = 32'hCAFE_F00D; req_err = 1;
        core_req = 1; core_addr = 32'h0000_3000;
        cycle();
        core_req = 0; req_err = 0; core_we = 0;
        repeat (4) cycle();

        // timeout abort, then a late ack
        mute = 1; core_req = 1; core_addr = 32'h0000_4000;
        cycle();
        core_addr = 32'h0000_4004;
        cycle();
        core_req = 0;
        repeat (14) cycle();
        mute = 0; spur = 1;
        cycle();
        spur = 0;
        repeat (2) cycle();

        // random traffic
        repeat (400) begin
            core_req   = $urandom_range(0, 3) != 0;
            core_we    = 1'($urandom);
            core_be    = 4'($urandom);
            core_addr  = $urandom;
            core_wdata = $urandom;
            wb_stall   = $urandom_range(0, 3) == 0;
            lat        = $urandom_range(1, 5);
            req_err    = $urandom_range(0, 9) == 0;
            both       = 1'($urandom);
            spur       = sq.size() == 0 && $urandom_range(0, 7) == 0;
            cycle();
        end
        core_req = 0; wb_stall = 0; spur = 0; both = 0; req_err = 0;
        repeat (12) cycle();

        // reset with three requests in flight
        mute = 1; core_req = 1;
        repeat (3) begin
            core_addr += 4;
            cycle();
        end
        core_req = 0;
        do_reset();
        mute = 0;
        repeat (3) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
